stitch_valid_pipeline: RTL

STITCH_VALID_PIPELINE -- requirements
Module: stitch_valid_pipeline

---
 rtl/stitch_pipeline_pkg.sv | 13 +
 rtl/stitch_pipeline_stage.sv | 44 ++++
 rtl/stitch_valid_pipeline.sv | 100 ++++++++++
 3 files changed

// File: rtl/stitch_pipeline_pkg.sv
// Shared defaults and helpers for the valid/ready add-constant pipeline.
package stitch_pipeline_pkg;

  localparam int unsigned DefaultWidth    = 32;
  localparam int unsigned DefaultStages   = 2;
  localparam int unsigned DefaultAddConst = 7;

  // Bits needed to count 0..stages occupied slots.
  function automatic int unsigned occ_width(input int unsigned stages);
    return $clog2(stages + 1);
  endfunction

endpackage

// File: rtl/stitch_pipeline_stage.sv
// One pipeline slot: valid bit, payload register and its add-constant input.
module stitch_pipeline_stage
  import stitch_pipeline_pkg::*;
#(
  parameter int unsigned WIDTH     = DefaultWidth,
  parameter int unsigned ADD_CONST = DefaultAddConst
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             up_valid_i,
  input  logic [WIDTH-1:0] up_data_i,
  input  logic             down_ready_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  localparam logic [WIDTH-1:0] AddConst = WIDTH'(ADD_CONST);

  logic             valid_q;
  logic [WIDTH-1:0] data_q;
  logic             ready;

  // Slot can take a new item if empty or if its current item leaves this cycle.
  assign ready = !valid_q || down_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (ready) begin
      valid_q <= up_valid_i;
      if (up_valid_i) begin
        data_q <= up_data_i + AddConst;
      end
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/stitch_valid_pipeline.sv
// Elastic valid/ready pipeline adding ADD_CONST per stage.
// Optional occupancy output enabled by STITCH_PIPELINE_OCCUPANCY_EN.
module stitch_valid_pipeline
  import stitch_pipeline_pkg::*;
#(
  parameter int unsigned WIDTH     = DefaultWidth,
  parameter int unsigned STAGES    = DefaultStages,
  parameter int unsigned ADD_CONST = DefaultAddConst
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef STITCH_PIPELINE_OCCUPANCY_EN
  ,
  output logic [occ_width(STAGES)-1:0] occupancy
`endif
);

  logic [STAGES-1:0] stage_valid;
  logic [STAGES-1:0] up_valid;
  logic [STAGES-1:0] down_ready;
  logic [WIDTH-1:0]  stage_data [STAGES];
  logic [WIDTH-1:0]  up_data    [STAGES];

  // Ready of the stage after k, computed as a flat scan to keep the chain inside one process.
  always_comb begin
    down_ready = '0;
    down_ready[STAGES-1] = out_ready;
    for (int k = STAGES - 2; k >= 0; k--) begin
      down_ready[k] = down_ready[k+1] || !stage_valid[k+1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign up_valid[k] = in_valid;
      assign up_data[k]  = in_data;
    end else begin : g_body
      assign up_valid[k] = stage_valid[k-1];
      assign up_data[k]  = stage_data[k-1];
    end

    stitch_pipeline_stage #(
      .WIDTH    (WIDTH),
      .ADD_CONST(ADD_CONST)
    ) u_stage (
      .clk_i       (clk),
      .rst_i       (rst),
      .flush_i     (flush),
      .up_valid_i  (up_valid[k]),
      .up_data_i   (up_data[k]),
      .down_ready_i(down_ready[k]),
      .valid_o     (stage_valid[k]),
      .data_o      (stage_data[k])
    );
  end

  assign in_ready  = (!stage_valid[0] || down_ready[0]) && !flush && !rst;
  assign out_valid = stage_valid[STAGES-1];
  assign out_data  = stage_data[STAGES-1];

`ifdef STITCH_PIPELINE_OCCUPANCY_EN
  localparam int unsigned OccWidth = occ_width(STAGES);

  logic [OccWidth-1:0] occ_d;
  logic [OccWidth-1:0] occ_q;

  // Count the valid bits as they will be after this edge.
  always_comb begin
    occ_d = '0;
    for (int k = 0; k < STAGES; k++) begin
      if (!stage_valid[k] || down_ready[k]) begin
        occ_d = occ_d + OccWidth'(up_valid[k]);
      end else begin
        occ_d = occ_d + OccWidth'(stage_valid[k]);
      end
    end
    if (rst || flush) begin
      occ_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occupancy = occ_q;
`endif

endmodule
